// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: joystick bit positions,
// PS/2 scan codes, key-state slots and the coin stretcher state encoding.
package arcade_input_pkg;

    // Bit positions inside one 16-bit joystick word
    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE_A = 4;
    localparam int JOY_FIRE_B = 5;
    localparam int JOY_FIRE_C = 6;
    localparam int JOY_FIRE_D = 7;
    localparam int JOY_START1 = 8;
    localparam int JOY_START2 = 9;
    localparam int JOY_COIN   = 10;

    // Slots in the keyboard key-state vector
    localparam int KEY_P1     = 0;
    localparam int KEY_P2     = 8;
    localparam int KEY_START1 = 16;
    localparam int KEY_START2 = 17;
    localparam int KEY_COIN1  = 18;
    localparam int KEY_COIN2  = 19;
    localparam int NUM_KEYS   = 20;

    // Player 1 scan codes
    localparam logic [8:0] SC_P1_UP     = 9'h075;
    localparam logic [8:0] SC_P1_DOWN   = 9'h072;
    localparam logic [8:0] SC_P1_LEFT   = 9'h06B;
    localparam logic [8:0] SC_P1_RIGHT  = 9'h074;
    localparam logic [8:0] SC_P1_FIRE_A = 9'h014;
    localparam logic [8:0] SC_P1_FIRE_B = 9'h011;
    localparam logic [8:0] SC_P1_FIRE_C = 9'h029;
    localparam logic [8:0] SC_P1_FIRE_D = 9'h012;

    // Player 2 scan codes
    localparam logic [8:0] SC_P2_UP     = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN   = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT   = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT  = 9'h034;
    localparam logic [8:0] SC_P2_FIRE_A = 9'h01C;
    localparam logic [8:0] SC_P2_FIRE_B = 9'h01B;
    localparam logic [8:0] SC_P2_FIRE_C = 9'h021;
    localparam logic [8:0] SC_P2_FIRE_D = 9'h01D;

    // System scan codes
    localparam logic [8:0] SC_START1_A = 9'h005;
    localparam logic [8:0] SC_START1_B = 9'h016;
    localparam logic [8:0] SC_START2_A = 9'h006;
    localparam logic [8:0] SC_START2_B = 9'h01E;
    localparam logic [8:0] SC_COIN1_A  = 9'h076;
    localparam logic [8:0] SC_COIN1_B  = 9'h02E;
    localparam logic [8:0] SC_COIN2    = 9'h036;

    // Coin counters are 17 bits wide so the default holdoff of 100000 fits
    localparam int COIN_CNT_W = 17;

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_ACTIVE,
        COIN_HOLDOFF,
        COIN_WAIT
    } coin_state_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_map_t;

    // Translate a scan code into its key-state slot; hit=0 for unknown codes
    function automatic key_map_t map_scan_code(input logic [8:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = 5'd0;
        case (code)
            SC_P1_RIGHT:  m.idx = 5'(KEY_P1 + JOY_RIGHT);
            SC_P1_LEFT:   m.idx = 5'(KEY_P1 + JOY_LEFT);
            SC_P1_DOWN:   m.idx = 5'(KEY_P1 + JOY_DOWN);
            SC_P1_UP:     m.idx = 5'(KEY_P1 + JOY_UP);
            SC_P1_FIRE_A: m.idx = 5'(KEY_P1 + JOY_FIRE_A);
            SC_P1_FIRE_B: m.idx = 5'(KEY_P1 + JOY_FIRE_B);
            SC_P1_FIRE_C: m.idx = 5'(KEY_P1 + JOY_FIRE_C);
            SC_P1_FIRE_D: m.idx = 5'(KEY_P1 + JOY_FIRE_D);
            SC_P2_RIGHT:  m.idx = 5'(KEY_P2 + JOY_RIGHT);
            SC_P2_LEFT:   m.idx = 5'(KEY_P2 + JOY_LEFT);
            SC_P2_DOWN:   m.idx = 5'(KEY_P2 + JOY_DOWN);
            SC_P2_UP:     m.idx = 5'(KEY_P2 + JOY_UP);
            SC_P2_FIRE_A: m.idx = 5'(KEY_P2 + JOY_FIRE_A);
            SC_P2_FIRE_B: m.idx = 5'(KEY_P2 + JOY_FIRE_B);
            SC_P2_FIRE_C: m.idx = 5'(KEY_P2 + JOY_FIRE_C);
            SC_P2_FIRE_D: m.idx = 5'(KEY_P2 + JOY_FIRE_D);
            SC_START1_A, SC_START1_B: m.idx = 5'(KEY_START1);
            SC_START2_A, SC_START2_B: m.idx = 5'(KEY_START2);
            SC_COIN1_A,  SC_COIN1_B:  m.idx = 5'(KEY_COIN1);
            SC_COIN2:                 m.idx = 5'(KEY_COIN2);
            default:                  m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_stretch.sv
// One coin channel: turns a request rising edge into a fixed-length coin
// pulse, then locks out re-triggering until a holdoff expires and the
// request has been released.
module coin_stretch
    import arcade_input_pkg::*;
#(
    parameter int unsigned PULSE   = 4,
    parameter int unsigned HOLDOFF = 0
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic req,
    output logic coin
);

    // Counters are loaded with length-1 so a state lasts exactly 'length' cycles
    localparam logic [COIN_CNT_W-1:0] PULSE_LOAD = COIN_CNT_W'(PULSE - 1);
    localparam logic [COIN_CNT_W-1:0] HOLD_LOAD  =
        COIN_CNT_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

    coin_state_t           state, state_next;
    logic [COIN_CNT_W-1:0] count, count_next;
    logic                  req_q;
    logic                  coin_next;

    // State register; reset copies the live request so a held request is not an edge
    always_ff @(posedge Clk) begin
        req_q <= req;
        if (!Rst_n) begin
            state <= COIN_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            COIN_IDLE: begin
                if (req && !req_q) begin
                    state_next = COIN_ACTIVE;
                    count_next = PULSE_LOAD;
                end
            end
            COIN_ACTIVE: begin
                if (count == '0) begin
                    if (HOLDOFF == 0) begin
                        state_next = COIN_WAIT;
                    end else begin
                        state_next = COIN_HOLDOFF;
                        count_next = HOLD_LOAD;
                    end
                end else begin
                    count_next = count - 1'b1;
                end
            end
            COIN_HOLDOFF: begin
                if (count == '0) begin
                    state_next = COIN_WAIT;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            COIN_WAIT: begin
                if (!req) begin
                    state_next = COIN_IDLE;
                end
            end
            default: begin
                state_next = COIN_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Output decode: coin follows the ACTIVE state one cycle later
    always_comb begin
        coin_next = (state == COIN_ACTIVE);
    end

    // Coin output register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            coin <= 1'b0;
        end else begin
            coin <= coin_next;
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keyboard events with joystick words into per-player controls,
// start buttons and stretched coin pulses, and holds the DIP/mod bytes
// written through the download port.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PLAYERS  = 2,
    parameter int          DIP_BYTES    = 8,
    parameter int unsigned COIN_PULSE   = 50000,
    parameter int unsigned COIN_HOLDOFF = 100000
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [10:0]                ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]  joy,
    input  logic                       ioctl_wr,
    input  logic [7:0]                 ioctl_index,
    input  logic [24:0]                ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    output logic [8*NUM_PLAYERS-1:0]   ctl,
    output logic [1:0]                 start,
    output logic [1:0]                 coin,
    output logic [8*DIP_BYTES-1:0]     dip,
    output logic [7:0]                 mod
);

    logic                      strobe_q;
    logic [NUM_KEYS-1:0]       key_state, key_state_next;
    key_map_t                  key_hit;
    logic [8*NUM_PLAYERS-1:0]  ctl_next;
    logic [1:0]                start_next;
    logic [1:0]                joy_start;
    logic                      joy_coin;
    logic [1:0]                coin_req;
    logic                      unused_joy_bits;

    // Apply a keyboard event to the key-state vector when the strobe toggles
    always_comb begin
        key_hit        = map_scan_code(ps2_key[8:0]);
        key_state_next = key_state;
        if ((ps2_key[10] != strobe_q) && key_hit.hit) begin
            key_state_next[key_hit.idx] = ps2_key[9];
        end
    end

    // Strobe copy always tracks ps2_key[10], so reset never leaves a stale event
    always_ff @(posedge Clk) begin
        strobe_q <= ps2_key[10];
        if (!Rst_n) begin
            key_state <= '0;
        end else begin
            key_state <= key_state_next;
        end
    end

    // OR keyboard state into the joystick words; only players 1 and 2 have keys
    always_comb begin
        ctl_next        = '0;
        joy_start       = 2'b00;
        joy_coin        = 1'b0;
        unused_joy_bits = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            ctl_next[8*p +: 8] = joy[16*p +: 8];
            if (p == 0) begin
                ctl_next[8*p +: 8] = ctl_next[8*p +: 8] | key_state_next[KEY_P1 +: 8];
            end else if (p == 1) begin
                ctl_next[8*p +: 8] = ctl_next[8*p +: 8] | key_state_next[KEY_P2 +: 8];
            end
            joy_start       = joy_start | joy[16*p + JOY_START1 +: 2];
            joy_coin        = joy_coin | joy[16*p + JOY_COIN];
            unused_joy_bits = unused_joy_bits ^ (^joy[16*p + 11 +: 5]);
        end
        start_next = joy_start | key_state_next[KEY_START1 +: 2];
        coin_req   = {key_state[KEY_COIN2], key_state[KEY_COIN1] | joy_coin};
    end

    // Registered control and start outputs
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ctl   <= '0;
            start <= 2'b00;
        end else begin
            ctl   <= ctl_next;
            start <= start_next;
        end
    end

    // Download port writes game configuration; deliberately kept through reset
    always_ff @(posedge Clk) begin
        if (ioctl_wr && (ioctl_index == 8'd1)) begin
            mod <= ioctl_dout;
        end
        if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr < 25'(DIP_BYTES))) begin
            for (int b = 0; b < DIP_BYTES; b++) begin
                if (ioctl_addr[2:0] == 3'(b)) begin
                    dip[8*b +: 8] <= ioctl_dout;
                end
            end
        end
    end

    coin_stretch #(
        .PULSE   (COIN_PULSE),
        .HOLDOFF (COIN_HOLDOFF)
    ) u_coin1 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .req   (coin_req[0]),
        .coin  (coin[0])
    );

    coin_stretch #(
        .PULSE   (COIN_PULSE),
        .HOLDOFF (COIN_HOLDOFF)
    ) u_coin2 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .req   (coin_req[1]),
        .coin  (coin[1])
    );

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed self-checking bench for arcade_input_mapper with four players,
// eight DIP bytes, a 4-cycle coin pulse and a 3-cycle holdoff.
module tb_arcade_input_mapper;

    localparam int NP = 4;
    localparam int DB = 8;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic [10:0]       ps2Key;
    logic [16*NP-1:0]  joy;
    logic              ioctlWr;
    logic [7:0]        ioctlIndex;
    logic [24:0]       ioctlAddr;
    logic [7:0]        ioctlDout;
    logic [8*NP-1:0]   ctl;
    logic [1:0]        start;
    logic [1:0]        coin;
    logic [8*DB-1:0]   dip;
    logic [7:0]        mod;

    int assertCount = 0;
    int failCount   = 0;

    int high0, high1, both, rise0, first0;
    logic [63:0] dipSaved;

    arcade_input_mapper #(
        .NUM_PLAYERS  (NP),
        .DIP_BYTES    (DB),
        .COIN_PULSE   (4),
        .COIN_HOLDOFF (3)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .ps2_key     (ps2Key),
        .joy         (joy),
        .ioctl_wr    (ioctlWr),
        .ioctl_index (ioctlIndex),
        .ioctl_addr  (ioctlAddr),
        .ioctl_dout  (ioctlDout),
        .ctl         (ctl),
        .start       (start),
        .coin        (coin),
        .dip         (dip),
        .mod         (mod)
    );

    // 10-time-unit clock
    always #5 Clk = ~Clk;

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with the expected one and count it
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and settle 1 unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Send one keyboard event by toggling the strobe, then clock it in
    task automatic applyStimulus(input logic [8:0] code, input logic pressed);
        ps2Key = {~ps2Key[10], pressed, code};
        tick(1);
    endtask

    // Watch the coin outputs for a number of cycles and tally what was seen
    task automatic measureCoin(input int cycles, output int h0, output int h1,
                               output int bth, output int r0, output int f0);
        logic prev0;
        h0 = 0; h1 = 0; bth = 0; r0 = 0; f0 = -1;
        prev0 = coin[0];
        for (int i = 1; i <= cycles; i++) begin
            tick(1);
            if (coin[0]) begin
                h0++;
                if (f0 < 0) f0 = i;
            end
            if (coin[0] && !prev0) r0++;
            if (coin[1]) h1++;
            if (coin == 2'b11) bth++;
            prev0 = coin[0];
        end
    endtask

    initial begin
        Rst_n      = 1'b0;
        ps2Key     = '0;
        joy        = '0;
        ioctlWr    = 1'b0;
        ioctlIndex = '0;
        ioctlAddr  = '0;
        ioctlDout  = '0;
        tick(3);

        // Reset state
        checkOutput("reset_ctl",   64'(ctl),   64'h0);
        checkOutput("reset_start", 64'(start), 64'h0);
        checkOutput("reset_coin",  64'(coin),  64'h0);

        // Strobe toggled during reset must not register as a key event
        ps2Key = {~ps2Key[10], 1'b1, 9'h029};
        tick(2);
        Rst_n = 1'b1;
        tick(2);
        checkOutput("no_spurious_event", 64'(ctl), 64'h0);

        // Fire C press, hold strobe, release
        applyStimulus(9'h029, 1'b1);
        checkOutput("fireC_press", 64'(ctl), 64'h40);
        tick(10);
        checkOutput("fireC_hold", 64'(ctl), 64'h40);
        applyStimulus(9'h029, 1'b0);
        checkOutput("fireC_release", 64'(ctl), 64'h0);

        // Unlisted code leaves everything alone
        applyStimulus(9'h0AA, 1'b1);
        checkOutput("unlisted_ctl",   64'(ctl),   64'h0);
        checkOutput("unlisted_start", 64'(start), 64'h0);

        // Player 2 up key
        applyStimulus(9'h02D, 1'b1);
        checkOutput("p2_up", 64'(ctl), 64'h800);
        applyStimulus(9'h02D, 1'b0);
        checkOutput("p2_up_release", 64'(ctl), 64'h0);

        // Joystick right merged with keyboard left
        joy[0] = 1'b1;
        applyStimulus(9'h06B, 1'b1);
        checkOutput("p1_merge", 64'(ctl), 64'h03);
        applyStimulus(9'h06B, 1'b0);
        joy = '0;
        tick(1);
        checkOutput("p1_merge_clear", 64'(ctl), 64'h0);

        // Start buttons from key and from player 2 joystick
        applyStimulus(9'h005, 1'b1);
        checkOutput("start1_key", 64'(start), 64'h1);
        joy[16*1 + 9] = 1'b1;
        tick(1);
        checkOutput("start_both", 64'(start), 64'h3);
        applyStimulus(9'h005, 1'b0);
        checkOutput("start2_joy", 64'(start), 64'h2);
        joy = '0;
        applyStimulus(9'h01E, 1'b1);
        checkOutput("start2_altkey", 64'(start), 64'h2);
        applyStimulus(9'h01E, 1'b0);
        checkOutput("start_clear", 64'(start), 64'h0);

        // Player 4 joystick, one cycle latency, others untouched
        joy[16*3 + 0] = 1'b1;
        #1;
        checkOutput("p4_before_edge", 64'(ctl), 64'h0);
        tick(1);
        checkOutput("p4_right", 64'(ctl), 64'h0100_0000);
        joy = '0;
        tick(1);

        // Joystick coin held 20 cycles gives one 4-cycle pulse
        joy[10] = 1'b1;
        measureCoin(20, high0, high1, both, rise0, first0);
        checkOutput("coin_joy_high", 64'(high0), 64'd4);
        checkOutput("coin_joy_rises", 64'(rise0), 64'd1);
        checkOutput("coin_joy_first", 64'(first0), 64'd2);
        checkOutput("coin_joy_coin2", 64'(high1), 64'd0);
        joy = '0;
        tick(2);
        joy[10] = 1'b1;
        measureCoin(12, high0, high1, both, rise0, first0);
        checkOutput("coin_repress_high", 64'(high0), 64'd4);
        checkOutput("coin_repress_rises", 64'(rise0), 64'd1);
        joy = '0;
        tick(2);

        // Coin1 by keyboard code 76
        applyStimulus(9'h076, 1'b1);
        measureCoin(12, high0, high1, both, rise0, first0);
        checkOutput("coin_key76_high", 64'(high0), 64'd4);
        checkOutput("coin_key76_first", 64'(first0), 64'd2);
        applyStimulus(9'h076, 1'b0);
        tick(2);

        // Coin2 key and coin1 request arriving together
        applyStimulus(9'h036, 1'b1);
        joy[16*2 + 10] = 1'b1;
        measureCoin(12, high0, high1, both, rise0, first0);
        checkOutput("coin_dual_both", 64'(both), 64'd4);
        checkOutput("coin_dual_c1", 64'(high0), 64'd4);
        checkOutput("coin_dual_c2", 64'(high1), 64'd4);
        applyStimulus(9'h036, 1'b0);
        joy = '0;
        tick(2);

        // Reset during ACTIVE with request held
        joy[10] = 1'b1;
        tick(2);
        checkOutput("coin_pre_reset", 64'(coin), 64'h1);
        Rst_n = 1'b0;
        tick(1);
        checkOutput("coin_in_reset", 64'(coin), 64'h0);
        tick(1);
        Rst_n = 1'b1;
        measureCoin(10, high0, high1, both, rise0, first0);
        checkOutput("coin_held_after_reset", 64'(high0), 64'd0);
        joy = '0;
        tick(2);
        joy[10] = 1'b1;
        measureCoin(8, high0, high1, both, rise0, first0);
        checkOutput("coin_after_rearm", 64'(high0), 64'd4);
        joy = '0;
        tick(8);

        // DIP writes, including out-of-range addresses
        for (int a = 0; a < 10; a++) begin
            ioctlWr    = 1'b1;
            ioctlIndex = 8'd254;
            ioctlAddr  = 25'(a);
            ioctlDout  = 8'hA0 + 8'(a);
            tick(1);
        end
        ioctlWr = 1'b0;
        tick(1);
        checkOutput("dip_bytes", dip, 64'hA7A6_A5A4_A3A2_A1A0);

        // Mod byte write, then a write on another index must not touch it
        ioctlWr    = 1'b1;
        ioctlIndex = 8'd1;
        ioctlAddr  = 25'd5;
        ioctlDout  = 8'h06;
        tick(1);
        ioctlIndex = 8'd2;
        ioctlDout  = 8'h55;
        tick(1);
        ioctlWr = 1'b0;
        tick(1);
        checkOutput("mod_write", 64'(mod), 64'h06);

        // Configuration survives reset
        dipSaved = dip;
        Rst_n = 1'b0;
        tick(3);
        checkOutput("mod_after_reset", 64'(mod), 64'h06);
        checkOutput("dip_after_reset", dip, 64'hA7A6_A5A4_A3A2_A1A0);
        checkOutput("dip_stable", dip, dipSaved);
        Rst_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
